fetch_align: RTL and testbench

- Fetch sequencer that sits between instruction memory and the decode stage.
- Issues word-aligned 32-bit fetches and buffers the returned halfwords.
- Extracts one complete RV32IC instruction at a time. A 16-bit instruction is any halfword with bits[1:0] != 2'b11; a 32-bit instruction spans two halfwords.
- Presents the instruction, its PC and its PC increment to decode over a valid/ready handshake. Handles redirects from branches and jumps.

---
 rtl/fetch_align_if.sv | 56 +++++
 rtl/fetch_align.sv | 208 ++++++++++++++++++++
 tb/tb_fetch_align.sv | 466 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_align_if.sv
// fetch_align_if: fetch memory port plus decode valid/ready port.
// Signals: O_mem_req/O_mem_addr/I_mem_rvalid/I_mem_rdata (memory),
//   O_valid/I_ready/O_instr/O_pc/O_pcincr (decode),
//   I_redirect/I_target (flush), O_illegal when
//   FETCH_ALIGN_ILLEGAL_CHECK_EN is defined.
// master = fetch_align side, slave = memory/decode side.
interface fetch_align_if;
  logic        O_mem_req;
  logic [31:0] O_mem_addr;
  logic        I_mem_rvalid;
  logic [31:0] I_mem_rdata;
  logic        O_valid;
  logic        I_ready;
  logic [31:0] O_instr;
  logic [31:0] O_pc;
  logic [31:0] O_pcincr;
  logic        I_redirect;
  logic [31:0] I_target;
`ifdef FETCH_ALIGN_ILLEGAL_CHECK_EN
  logic        O_illegal;
`endif

  modport master (
    output O_mem_req,
    output O_mem_addr,
    input  I_mem_rvalid,
    input  I_mem_rdata,
    output O_valid,
    input  I_ready,
    output O_instr,
    output O_pc,
    output O_pcincr,
    input  I_redirect,
    input  I_target
`ifdef FETCH_ALIGN_ILLEGAL_CHECK_EN
    ,output O_illegal
`endif
  );

  modport slave (
    input  O_mem_req,
    input  O_mem_addr,
    output I_mem_rvalid,
    output I_mem_rdata,
    input  O_valid,
    output I_ready,
    input  O_instr,
    input  O_pc,
    input  O_pcincr,
    output I_redirect,
    output I_target
`ifdef FETCH_ALIGN_ILLEGAL_CHECK_EN
    ,input O_illegal
`endif
  );
endinterface

// File: rtl/fetch_align.sv
// fetch_align: RV32IC fetch sequencer with a 3-halfword align buffer.
// Ports: I_clk; I_rst (synchronous, active-high); bus
//   (fetch_align_if.master): memory request/response, decode
//   valid/ready with instr/pc/pcincr, and redirect/target.
// Macro FETCH_ALIGN_ILLEGAL_CHECK_EN adds bus.O_illegal.
module fetch_align #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          I_clk,
  input  logic          I_rst,
  fetch_align_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  localparam logic [31:0] RST_FADDR =
    {RESET_PC[31:2], 2'b00};
  localparam logic [31:0] RST_PC =
    {RESET_PC[31:1], 1'b0};

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_hb [3];
  logic [1:0]  r_cnt;
  logic [31:0] r_faddr;
  logic        r_skip_lo;
  logic [31:0] r_pc;

  logic        w_head_16;
  logic        w_valid;
  logic        w_accept;
  logic [1:0]  w_pop;
  logic [1:0]  w_rem;
  logic        w_rsp_ok;
  logic        w_req;
  logic [15:0] w_rsp_lo;
  logic [15:0] w_rsp_hi;
  logic [15:0] w_sh [3];
  logic [15:0] w_hb_nxt [3];
  logic [1:0]  w_cnt_nxt;
  logic [31:0] w_instr;
  logic [31:0] w_pcincr;
  logic        w_unused;

  // Target bit 0 is meaningless for halfword-aligned code.
  assign w_unused = bus.I_target[0];

  assign w_head_16 = (r_hb[0][1:0] != 2'b11);
  assign w_valid   = ((r_cnt != 2'd0) && w_head_16)
                   || (r_cnt >= 2'd2);
  assign w_accept  = w_valid && bus.I_ready
                   && !bus.I_redirect;

  // Halfwords leaving the head this cycle.
  assign w_pop = !w_accept ? 2'd0
               : (w_head_16 ? 2'd1 : 2'd2);
  assign w_rem = r_cnt - w_pop;

  // Data is only kept when no redirect races it.
  assign w_rsp_ok = (r_state == S_WAIT)
                  && bus.I_mem_rvalid
                  && !bus.I_redirect;

  assign w_rsp_lo = bus.I_mem_rdata[15:0];
  assign w_rsp_hi = bus.I_mem_rdata[31:16];

  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        // cnt<=1 leaves room for a full word.
        if ((r_cnt <= 2'd1) && !bus.I_redirect
            && !I_rst) begin
          w_req       = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.I_mem_rvalid) begin
          w_state_nxt = S_IDLE;
        end else if (bus.I_redirect) begin
          w_state_nxt = S_DROP;
        end
      end
      S_DROP: begin
        if (bus.I_mem_rvalid) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Shift the survivors down to the head.
  always_comb begin
    w_sh = r_hb;
    case (w_pop)
      2'd1: begin
        w_sh[0] = r_hb[1];
        w_sh[1] = r_hb[2];
        w_sh[2] = '0;
      end
      2'd2: begin
        w_sh[0] = r_hb[2];
        w_sh[1] = '0;
        w_sh[2] = '0;
      end
      default: begin
      end
    endcase
  end

  // Append fresh halfwords behind the survivors.
  always_comb begin
    w_hb_nxt  = w_sh;
    w_cnt_nxt = w_rem;
    if (w_rsp_ok) begin
      if (r_skip_lo) begin
        case (w_rem)
          2'd0:    w_hb_nxt[0] = w_rsp_hi;
          2'd1:    w_hb_nxt[1] = w_rsp_hi;
          default: w_hb_nxt[2] = w_rsp_hi;
        endcase
        w_cnt_nxt = w_rem + 2'd1;
      end else begin
        case (w_rem)
          2'd0: begin
            w_hb_nxt[0] = w_rsp_lo;
            w_hb_nxt[1] = w_rsp_hi;
          end
          default: begin
            w_hb_nxt[1] = w_rsp_lo;
            w_hb_nxt[2] = w_rsp_hi;
          end
        endcase
        w_cnt_nxt = w_rem + 2'd2;
      end
    end
  end

  always_comb begin
    w_instr  = '0;
    w_pcincr = 32'h4;
    unique case (1'b1)
      (w_valid && w_head_16): begin
        w_instr  = {16'h0000, r_hb[0]};
        w_pcincr = 32'h2;
      end
      (w_valid && !w_head_16): begin
        w_instr  = {r_hb[1], r_hb[0]};
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      r_state   <= S_IDLE;
      r_hb      <= '{default: '0};
      r_cnt     <= 2'd0;
      r_faddr   <= RST_FADDR;
      r_skip_lo <= RESET_PC[1];
      r_pc      <= RST_PC;
    end else begin
      r_state <= w_state_nxt;
      if (bus.I_redirect) begin
        r_cnt     <= 2'd0;
        r_pc      <= {bus.I_target[31:1], 1'b0};
        r_faddr   <= {bus.I_target[31:2], 2'b00};
        r_skip_lo <= bus.I_target[1];
      end else begin
        r_hb  <= w_hb_nxt;
        r_cnt <= w_cnt_nxt;
        if (w_accept) begin
          r_pc <= r_pc + w_pcincr;
        end
        if (w_rsp_ok) begin
          r_faddr   <= r_faddr + 32'h4;
          r_skip_lo <= 1'b0;
        end
      end
    end
  end

  assign bus.O_mem_req  = w_req;
  assign bus.O_mem_addr = r_faddr;
  assign bus.O_valid    = w_valid;
  assign bus.O_instr    = w_instr;
  assign bus.O_pc       = r_pc;
  assign bus.O_pcincr   = w_pcincr;

`ifdef FETCH_ALIGN_ILLEGAL_CHECK_EN
  logic w_illegal;
  assign w_illegal = w_valid && (w_head_16
    ? (r_hb[0] == 16'h0000)
    : ({r_hb[1], r_hb[0]} == 32'hFFFF_FFFF));
  assign bus.O_illegal = w_illegal;
`endif

endmodule

// File: tb/tb_fetch_align.sv
// tb_fetch_align: randomized and directed bench for fetch_align.
// Reference model walks a halfword memory image by PC.
module tb_fetch_align;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_align_if bus ();

  fetch_align #(.RESET_PC(32'h0)) dut (
    .I_clk(clk),
    .I_rst(rst),
    .bus  (bus)
  );

  int n_chk = 0;
  int n_pass = 0;
  int n_req = 0;

  logic [31:0] mem [256];
  bit          pend;
  int          wcnt;
  logic [31:0] paddr;
  int          lat_min = 1;
  int          lat_max = 1;

  function automatic logic [15:0] hw(input logic [31:0] a);
    logic [31:0] w;
    w = mem[a[9:2]];
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  function automatic logic [31:0] ref_instr(input logic [31:0] pc);
    logic [15:0] lo;
    lo = hw(pc);
    if (lo[1:0] != 2'b11) return {16'h0000, lo};
    return {hw(pc + 32'h2), lo};
  endfunction

  function automatic logic [31:0] ref_incr(input logic [31:0] pc);
    logic [15:0] lo;
    lo = hw(pc);
    return (lo[1:0] != 2'b11) ? 32'h2 : 32'h4;
  endfunction

  task automatic drive_mem();
    bus.I_mem_rvalid = 1'b0;
    bus.I_mem_rdata  = $urandom;
    if (pend) begin
      if (wcnt == 0) begin
        bus.I_mem_rvalid = 1'b1;
        bus.I_mem_rdata  = mem[paddr[9:2]];
        pend = 1'b0;
      end else begin
        wcnt--;
      end
    end
  endtask

  task automatic advance();
    #1;
    if (bus.O_mem_req && !rst) begin
      pend  = 1'b1;
      paddr = bus.O_mem_addr;
      wcnt  = int'($urandom_range(lat_max - 1, lat_min - 1));
      n_req++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.I_ready      = 1'b0;
    bus.I_redirect   = 1'b0;
    bus.I_target     = '0;
    bus.I_mem_rvalid = 1'b0;
    bus.I_mem_rdata  = '0;
    pend = 1'b0;
    advance();
    advance();
    rst = 1'b0;
    lat_min = 1;
    lat_max = 1;
  endtask

  task automatic run_acc(input int budget, output bit got,
                         output logic [31:0] pc,
                         output logic [31:0] ins,
                         output logic [31:0] inc);
    got = 1'b0;
    pc  = '0;
    ins = '0;
    inc = '0;
    for (int i = 0; i < budget && !got; i++) begin
      bus.I_ready    = 1'b1;
      bus.I_redirect = 1'b0;
      drive_mem();
      #1;
      if (bus.O_valid) begin
        got = 1'b1;
        pc  = bus.O_pc;
        ins = bus.O_instr;
        inc = bus.O_pcincr;
      end
      advance();
    end
  endtask

  task automatic test_reset();
    do_reset();
    bus.I_ready = 1'b0;
    drive_mem();
    advance();
    rst = 1'b1;
    drive_mem();
    #1;
    n_chk++;
    if (bus.O_mem_req !== 1'b0)
      $display("FAIL reset_req: got %b want 0", bus.O_mem_req);
    else n_pass++;
    advance();
    #1;
    n_chk++;
    if (bus.O_valid !== 1'b0)
      $display("FAIL reset_valid: got %b want 0", bus.O_valid);
    else n_pass++;
    n_chk++;
    if (bus.O_instr !== 32'h0)
      $display("FAIL reset_instr: got %h want 0", bus.O_instr);
    else n_pass++;
    n_chk++;
    if (bus.O_pcincr !== 32'h4)
      $display("FAIL reset_pcincr: got %h want 4", bus.O_pcincr);
    else n_pass++;
    n_chk++;
    if (bus.O_pc !== 32'h0)
      $display("FAIL reset_pc: got %h want 0", bus.O_pc);
    else n_pass++;
    rst = 1'b0;
    bus.I_mem_rvalid = 1'b1;
    bus.I_mem_rdata  = 32'h0001_0001;
    #1;
    n_chk++;
    if ({bus.O_mem_req, bus.O_mem_addr} !== {1'b1, 32'h0})
      $display("FAIL reset_first_req: got %b/%h want 1/0",
               bus.O_mem_req, bus.O_mem_addr);
    else n_pass++;
    advance();
    drive_mem();
    #1;
    n_chk++;
    if (bus.O_valid !== 1'b0)
      $display("FAIL reset_stale_rvalid: got %b want 0", bus.O_valid);
    else n_pass++;
    advance();
    drive_mem();
    #1;
    n_chk++;
    if ({bus.O_valid, bus.O_pc, bus.O_instr}
        !== {1'b1, 32'h0, ref_instr(32'h0)})
      $display("FAIL reset_first_instr: got %b/%h/%h want 1/0/%h",
               bus.O_valid, bus.O_pc, bus.O_instr, ref_instr(32'h0));
    else n_pass++;
    advance();
  endtask

  task automatic test_basic();
    logic [31:0] e_pc [4];
    logic [31:0] e_in [4];
    logic [31:0] e_inc [4];
    logic [31:0] pc, ins, inc;
    bit got;
    e_pc  = '{32'h0, 32'h4, 32'h0, 32'h2};
    e_in  = '{32'h00A00093, 32'h00000013,
              32'h00004501, 32'h00A00093};
    e_inc = '{32'h4, 32'h4, 32'h2, 32'h4};
    for (int i = 0; i < 4; i++) begin
      if (i == 0) begin
        mem[0] = 32'h00A00093;
        mem[1] = 32'h00000013;
        do_reset();
      end
      if (i == 2) begin
        mem[0] = 32'h00934501;
        mem[1] = 32'h000000A0;
        do_reset();
      end
      run_acc(20, got, pc, ins, inc);
      n_chk++;
      if (!got || {pc, ins, inc} !== {e_pc[i], e_in[i], e_inc[i]})
        $display("FAIL basic_%0d: got %0b pc=%h ins=%h inc=%h want pc=%h ins=%h inc=%h",
                 i, got, pc, ins, inc, e_pc[i], e_in[i], e_inc[i]);
      else n_pass++;
    end
  endtask

  task automatic test_redirect();
    logic [31:0] pc, ins, inc;
    bit got;
    mem[8'h41] = 32'h4501_0001;
    do_reset();
    lat_min = 3;
    lat_max = 3;
    bus.I_ready = 1'b0;
    drive_mem();
    #1;
    n_chk++;
    if ({bus.O_mem_req, bus.O_mem_addr} !== {1'b1, 32'h0})
      $display("FAIL redir_req0: got %b/%h want 1/0",
               bus.O_mem_req, bus.O_mem_addr);
    else n_pass++;
    advance();
    lat_min = 1;
    lat_max = 1;
    bus.I_redirect = 1'b1;
    bus.I_target   = 32'h0000_0106;
    drive_mem();
    advance();
    bus.I_redirect = 1'b0;
    for (int c = 0; c < 2; c++) begin
      drive_mem();
      #1;
      n_chk++;
      if ({bus.O_mem_req, bus.O_valid} !== 2'b00)
        $display("FAIL redir_drop_%0d: got req=%b valid=%b want 0/0",
                 c, bus.O_mem_req, bus.O_valid);
      else n_pass++;
      advance();
    end
    drive_mem();
    #1;
    n_chk++;
    if ({bus.O_mem_req, bus.O_mem_addr} !== {1'b1, 32'h104})
      $display("FAIL redir_req1: got %b/%h want 1/104",
               bus.O_mem_req, bus.O_mem_addr);
    else n_pass++;
    advance();
    run_acc(20, got, pc, ins, inc);
    n_chk++;
    if (!got || {pc, ins, inc} !== {32'h106, 32'h4501, 32'h2})
      $display("FAIL redir_first: got %0b pc=%h ins=%h inc=%h want 106/4501/2",
               got, pc, ins, inc);
    else n_pass++;
  endtask

  task automatic test_stall();
    logic [31:0] s_pc, s_in, pc, ins, inc;
    bit have, got;
    int r0;
    for (int i = 0; i < 8; i++)
      mem[i] = ($urandom & 32'hFFFC_FFFC) | 32'h0001_0001;
    do_reset();
    r0 = n_req;
    have = 1'b0;
    s_pc = '0;
    s_in = '0;
    for (int c = 0; c < 10; c++) begin
      bus.I_ready    = 1'b0;
      bus.I_redirect = 1'b0;
      drive_mem();
      #1;
      if (have) begin
        n_chk++;
        if ({bus.O_valid, bus.O_pc, bus.O_instr} !== {1'b1, s_pc, s_in})
          $display("FAIL stall_stable_%0d: got %b/%h/%h want 1/%h/%h",
                   c, bus.O_valid, bus.O_pc, bus.O_instr, s_pc, s_in);
        else n_pass++;
      end else if (bus.O_valid) begin
        have = 1'b1;
        s_pc = bus.O_pc;
        s_in = bus.O_instr;
      end
      advance();
    end
    n_chk++;
    if (!have || s_pc !== 32'h0)
      $display("FAIL stall_valid: got %0b pc=%h want 1 pc=0", have, s_pc);
    else n_pass++;
    n_chk++;
    if (n_req - r0 != 1)
      $display("FAIL stall_reqs: got %0d want 1", n_req - r0);
    else n_pass++;
    for (int i = 0; i < 6; i++) begin
      run_acc(20, got, pc, ins, inc);
      n_chk++;
      if (!got || {pc, ins, inc}
          !== {32'(2 * i), ref_instr(32'(2 * i)), 32'h2})
        $display("FAIL stall_acc_%0d: got %0b pc=%h ins=%h inc=%h want pc=%h ins=%h inc=2",
                 i, got, pc, ins, inc, 2 * i, ref_instr(32'(2 * i)));
      else n_pass++;
    end
  endtask

  task automatic test_redirect_accept();
    logic [31:0] pc, ins, inc;
    bit have, got;
    do_reset();
    have = 1'b0;
    for (int c = 0; c < 10 && !have; c++) begin
      bus.I_ready    = 1'b0;
      bus.I_redirect = 1'b0;
      drive_mem();
      #1;
      if (bus.O_valid) begin
        have = 1'b1;
        bus.I_ready    = 1'b1;
        bus.I_redirect = 1'b1;
        bus.I_target   = 32'h0000_02A6;
      end
      advance();
    end
    bus.I_redirect = 1'b0;
    bus.I_ready    = 1'b0;
    drive_mem();
    #1;
    n_chk++;
    if ({have, bus.O_valid, bus.O_pc} !== {1'b1, 1'b0, 32'h2A6})
      $display("FAIL redacc_next: got have=%0b valid=%b pc=%h want 1/0/2a6",
               have, bus.O_valid, bus.O_pc);
    else n_pass++;
    advance();
    run_acc(20, got, pc, ins, inc);
    n_chk++;
    if (!got || {pc, ins, inc}
        !== {32'h2A6, ref_instr(32'h2A6), ref_incr(32'h2A6)})
      $display("FAIL redacc_first: got %0b pc=%h ins=%h inc=%h want 2a6/%h/%h",
               got, pc, ins, inc, ref_instr(32'h2A6), ref_incr(32'h2A6));
    else n_pass++;
  endtask

  task automatic test_wrap();
    logic [31:0] e_pc [3];
    logic [31:0] pc, ins, inc;
    bit got;
    e_pc = '{32'hFFFF_FFFC, 32'hFFFF_FFFE, 32'h0};
    mem[255] = 32'h0005_0009;
    do_reset();
    bus.I_redirect = 1'b1;
    bus.I_target   = 32'hFFFF_FFFC;
    drive_mem();
    advance();
    for (int i = 0; i < 3; i++) begin
      run_acc(20, got, pc, ins, inc);
      n_chk++;
      if (!got || {pc, ins, inc}
          !== {e_pc[i], ref_instr(e_pc[i]), ref_incr(e_pc[i])})
        $display("FAIL wrap_%0d: got %0b pc=%h ins=%h inc=%h want pc=%h ins=%h inc=%h",
                 i, got, pc, ins, inc, e_pc[i],
                 ref_instr(e_pc[i]), ref_incr(e_pc[i]));
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [31:0] m_pc, p_pc, p_in, e_in, e_inc;
    bit p_stall;
    int n_acc;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    do_reset();
    lat_min = 1;
    lat_max = 3;
    m_pc = 32'h0;
    p_stall = 1'b0;
    p_pc = '0;
    p_in = '0;
    n_acc = 0;
    for (int c = 0; c < 3000; c++) begin
      bus.I_ready    = ($urandom_range(0, 9) < 7);
      bus.I_redirect = ($urandom_range(0, 39) == 0);
      bus.I_target   = 32'($urandom_range(0, 1023));
      drive_mem();
      #1;
      if (bus.O_mem_req) begin
        n_chk++;
        if (pend || bus.O_mem_addr[1:0] !== 2'b00)
          $display("FAIL rnd_req_%0d: got pend=%0b addr=%h want no pending, aligned",
                   c, pend, bus.O_mem_addr);
        else n_pass++;
      end
      if (p_stall) begin
        n_chk++;
        if ({bus.O_valid, bus.O_pc, bus.O_instr} !== {1'b1, p_pc, p_in})
          $display("FAIL rnd_stable_%0d: got %b/%h/%h want 1/%h/%h",
                   c, bus.O_valid, bus.O_pc, bus.O_instr, p_pc, p_in);
        else n_pass++;
      end
      if (bus.O_valid && bus.I_ready && !bus.I_redirect) begin
        e_in  = ref_instr(m_pc);
        e_inc = ref_incr(m_pc);
        n_chk++;
        if ({bus.O_pc, bus.O_instr, bus.O_pcincr} !== {m_pc, e_in, e_inc})
          $display("FAIL rnd_acc_%0d: got pc=%h ins=%h inc=%h want pc=%h ins=%h inc=%h",
                   c, bus.O_pc, bus.O_instr, bus.O_pcincr, m_pc, e_in, e_inc);
        else n_pass++;
        m_pc = m_pc + e_inc;
        n_acc++;
      end
      if (bus.I_redirect) m_pc = {bus.I_target[31:1], 1'b0};
      p_stall = bus.O_valid && !bus.I_ready && !bus.I_redirect;
      p_pc = bus.O_pc;
      p_in = bus.O_instr;
      advance();
    end
    n_chk++;
    if (n_acc < 300)
      $display("FAIL rnd_progress: got %0d accepts want >= 300", n_acc);
    else n_pass++;
  endtask

`ifdef FETCH_ALIGN_ILLEGAL_CHECK_EN
  task automatic test_illegal();
    logic [31:0] pc, ins, inc;
    bit have, got;
    mem[0] = 32'h0000_0000;
    do_reset();
    have = 1'b0;
    for (int c = 0; c < 10 && !have; c++) begin
      bus.I_ready    = 1'b0;
      bus.I_redirect = 1'b0;
      drive_mem();
      #1;
      if (bus.O_valid) begin
        have = 1'b1;
        n_chk++;
        if ({bus.O_illegal, bus.O_pcincr} !== {1'b1, 32'h2})
          $display("FAIL illegal_flag: got %b/%h want 1/2",
                   bus.O_illegal, bus.O_pcincr);
        else n_pass++;
      end
      advance();
    end
    run_acc(20, got, pc, ins, inc);
    n_chk++;
    if (!have || !got || {pc, ins, inc} !== {32'h0, 32'h0, 32'h2})
      $display("FAIL illegal_acc: got %0b/%0b pc=%h ins=%h inc=%h want 0/0/2",
               have, got, pc, ins, inc);
    else n_pass++;
  endtask
`endif

  initial begin
    bus.I_ready      = 1'b0;
    bus.I_redirect   = 1'b0;
    bus.I_target     = '0;
    bus.I_mem_rvalid = 1'b0;
    bus.I_mem_rdata  = '0;
    pend = 1'b0;
    wcnt = 0;
    paddr = '0;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    @(negedge clk);
    test_reset();
    test_basic();
    test_redirect();
    test_stall();
    test_redirect_accept();
    test_wrap();
    test_random();
`ifdef FETCH_ALIGN_ILLEGAL_CHECK_EN
    test_illegal();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
